multi_ch_tick_gen: RTL and testbench

Programmable multi-channel timing generator: replaces fixed divided clocks with NUM_CH independent clock-enable tick strobes and duty-programmable square-wave outputs, all synchronous to the single system clock. Each channel has a runtime-writable period and high time, with glitch-free updates at period boundaries. It feeds timing control (1 kHz ticks) and tone generation (buzzer square waves), and new rates need no RTL change.

---
 rtl/multi_ch_tick_gen.sv | 100 ++++++++++
 tb/tb_multi_ch_tick_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_tick_gen.sv
// Multi-channel programmable tick / square-wave generator.
// Each channel has a shadowed {period, high time} pair that becomes active at period boundaries.
module multi_ch_tick_gen #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEF_DIV  = 24999,
  parameter int unsigned DEF_HIGH = 12500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] wave
);

  localparam int unsigned CH_W = 4;

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
  } tcfg_t;

  localparam tcfg_t DEF_CFG = '{div: CNT_W'(DEF_DIV), high: CNT_W'(DEF_HIGH)};

  tcfg_t              shad_q [NUM_CH];
  tcfg_t              shad_d [NUM_CH];
  tcfg_t              act_q  [NUM_CH];
  tcfg_t              act_d  [NUM_CH];
  logic [CNT_W-1:0]   cnt_q  [NUM_CH];
  logic [CNT_W-1:0]   cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]  tick_q, tick_d;
  logic [NUM_CH-1:0]  wave_q, wave_d;

  logic               cfg_ok_c;
  tcfg_t              cfg_in_c;

  // Out-of-range channel indices are dropped here so no channel ever sees them.
  assign cfg_ok_c = cfg_wr && ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
  assign cfg_in_c = '{div: cfg_div, high: cfg_high};

  // Per-channel next state; active load takes shad_d so a same-cycle write bypasses the shadow.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      shad_d[i] = shad_q[i];
      act_d[i]  = act_q[i];
      cnt_d[i]  = cnt_q[i];
      tick_d[i] = 1'b0;
      wave_d[i] = 1'b0;

      if (cfg_ok_c && (cfg_ch == CH_W'(i))) begin
        shad_d[i] = cfg_in_c;
      end

      if (!ch_en[i]) begin
        cnt_d[i] = '0;
        act_d[i] = shad_d[i];
      end else begin
        wave_d[i] = (cnt_q[i] < act_q[i].high);
        if (sync) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == act_q[i].div) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          act_d[i]  = shad_d[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        shad_q[i] <= DEF_CFG;
        act_q[i]  <= DEF_CFG;
        cnt_q[i]  <= '0;
      end
      tick_q <= '0;
      wave_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        shad_q[i] <= shad_d[i];
        act_q[i]  <= act_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      tick_q <= tick_d;
      wave_q <= wave_d;
    end
  end

  assign tick = tick_q;
  assign wave = wave_q;

endmodule

// File: tb/tb_multi_ch_tick_gen.sv
// Directed bench for multi_ch_tick_gen: per-cycle expectations come from closed-form
// period formulas per channel, queued before each edge and compared after it.
module tb_multi_ch_tick_gen;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DEF_DIV  = 24999;
  localparam int unsigned DEF_HIGH = 12500;

  logic              clk;
  logic              rst_n;
  logic              cfg_wr;
  logic [3:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_high;
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] wave;

  int checks = 0;
  int errors = 0;

  // Channel description: enabled flag, edge count before first edge of the current period train, div, high.
  int cyc;
  int en_m    [NUM_CH];
  int start_m [NUM_CH];
  int div_m   [NUM_CH];
  int high_m  [NUM_CH];

  typedef struct {
    string             tag;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] wave;
  } exp_t;

  exp_t sb_q[$];

  multi_ch_tick_gen #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV),
    .DEF_HIGH(DEF_HIGH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_high(cfg_high),
    .ch_en   (ch_en),
    .sync    (sync),
    .tick    (tick),
    .wave    (wave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Push the expectation for the coming edge, clock it, then pop and compare.
  task automatic step(input string tag);
    exp_t e;
    int   k;
    e.tag  = tag;
    e.tick = '0;
    e.wave = '0;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      if (en_m[ch] != 0) begin
        k = cyc + 1 - start_m[ch];
        e.tick[ch] = (sync == 1'b0) && ((k % (div_m[ch] + 1)) == 0);
        e.wave[ch] = (((k - 1) % (div_m[ch] + 1)) < high_m[ch]);
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    cyc++;
    if (sync) begin
      for (int ch = 0; ch < int'(NUM_CH); ch++) begin
        if (en_m[ch] != 0) start_m[ch] = cyc;
      end
    end
    #1;
    e = sb_q.pop_front();
    chk({e.tag, " tick"}, tick, e.tick);
    chk({e.tag, " wave"}, wave, e.wave);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_en(input int ch, input bit v);
    ch_en[ch] = v;
    en_m[ch]  = v ? 1 : 0;
    if (v) start_m[ch] = cyc;
  endtask

  // A write to a disabled channel is live immediately; enabled channels are updated by the caller.
  task automatic wr_step(input string tag, input int ch, input int d, input int h);
    cfg_wr   = 1'b1;
    cfg_ch   = 4'(ch);
    cfg_div  = CNT_W'(d);
    cfg_high = CNT_W'(h);
    step(tag);
    cfg_wr = 1'b0;
    if (ch < int'(NUM_CH)) begin
      if (en_m[ch] == 0) begin
        div_m[ch]  = d;
        high_m[ch] = h;
      end
    end
  endtask

  task automatic reset_model();
    cyc = 0;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      en_m[ch]    = 1;
      start_m[ch] = 0;
      div_m[ch]   = int'(DEF_DIV);
      high_m[ch]  = int'(DEF_HIGH);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    ch_en    = '1;
    cfg_wr   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    cfg_high = '0;
    sync     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tick", tick, '0);
    chk("reset wave", wave, '0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();

    // Default 25000-cycle period, two full ticks.
    run("def_period", 50001);

    // Program every channel while disabled.
    for (int ch = 0; ch < int'(NUM_CH); ch++) set_en(ch, 1'b0);
    step("disable");
    wr_step("cfg0", 0, 3, 2);
    wr_step("cfg1", 1, 9, 5);
    wr_step("cfg2_high0", 2, 3, 0);
    wr_step("cfg3_high7", 3, 3, 7);

    // Enable all; reprogram ch1 at cnt=5, the 10-cycle period must finish first.
    for (int ch = 0; ch < int'(NUM_CH); ch++) set_en(ch, 1'b1);
    run("run_a", 5);
    wr_step("reprog1", 1, 4, 2);
    run("old_period", 4);
    start_m[1] = cyc;
    div_m[1]   = 4;
    high_m[1]  = 2;
    run("new_period", 15);

    // div=0: tick every cycle.
    set_en(2, 1'b0);
    wr_step("cfg2_div0", 2, 0, 1);
    set_en(2, 1'b1);
    run("div0", 6);

    // ch0/ch1 at div=7, started out of phase, then aligned by sync.
    set_en(0, 1'b0);
    set_en(1, 1'b0);
    wr_step("cfg0_div7", 0, 7, 4);
    wr_step("cfg1_div7", 1, 7, 4);
    set_en(0, 1'b1);
    run("phase0", 3);
    set_en(1, 1'b1);
    run("phase1", 5);
    sync = 1'b1;
    step("sync");
    sync = 1'b0;
    run("aligned", 15);

    // Sync landing on the boundary edge swallows that tick.
    sync = 1'b1;
    step("sync_bnd");
    sync = 1'b0;
    run("after_sync_bnd", 12);

    // Out-of-range channel index must not disturb anything.
    wr_step("bad_ch", int'(NUM_CH), 1, 1);
    run("no_change", 20);

    // Async reset mid-period while ch2 tick and ch3 wave are high.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst tick", tick, '0);
    chk("async_rst wave", wave, '0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    run("def_after_rst", 25001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
